// File: rtl/fma_dot_product_sequencer.sv
// fma_dot_product_sequencer
//
// Drives a slow fused multiply-add unit to evaluate
//   result = bias +/- sum(term_a[i] * term_b[i])
// over a stream of term_count operand pairs. Each term issues exactly one FMA
// operation, and the FMA result is fed back as the next c operand. The
// sequencer does no arithmetic of its own. Width, rounding and wrap behaviour
// all come from the FMA. The only arithmetic here is the remaining-term
// decrement.
//
// Ports
//   clock, reset          system clock, synchronous active-high reset
//   start                 begin an operation (sampled only while idle)
//   term_count            number of pairs, saturated to max_terms
//   bias                  initial accumulator value
//   negate_products       1: products are subtracted from the accumulator
//   term_valid/ready      operand pair stream handshake (term_a, term_b)
//   fma_input_valid/ready FMA request handshake (fma_a, fma_b, fma_c, fma_opcode)
//   fma_output_valid      FMA result flag, fma_r carries the result
//   busy                  high whenever an operation is in progress
//   result_valid/ready    final accumulator handshake (result)
module fma_dot_product_sequencer #(
    parameter int max_terms = 8,
    parameter int DATA_W    = 32,
    localparam int CNT_W    = $clog2(max_terms + 1)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     start,
    input  logic [CNT_W-1:0]         term_count,
    input  logic signed [DATA_W-1:0] bias,
    input  logic                     negate_products,
    input  logic                     term_valid,
    output logic                     term_ready,
    input  logic signed [DATA_W-1:0] term_a,
    input  logic signed [DATA_W-1:0] term_b,
    output logic                     fma_input_valid,
    input  logic                     fma_input_ready,
    output logic signed [DATA_W-1:0] fma_a,
    output logic signed [DATA_W-1:0] fma_b,
    output logic signed [DATA_W-1:0] fma_c,
    output logic [1:0]               fma_opcode,
    input  logic                     fma_output_valid,
    input  logic signed [DATA_W-1:0] fma_r,
    output logic                     busy,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic signed [DATA_W-1:0] result
);

    localparam logic [1:0] OPC_POS_A_POS_C = 2'd0;
    localparam logic [1:0] OPC_NEG_A_POS_C = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                     state_q, state_d;
    logic signed [DATA_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]           rem_q, rem_d;
    logic                       neg_q, neg_d;
    logic                       first_wait_q, first_wait_d;
    logic signed [DATA_W-1:0]   fma_a_q, fma_a_d;
    logic signed [DATA_W-1:0]   fma_b_q, fma_b_d;
    logic signed [DATA_W-1:0]   fma_c_q, fma_c_d;
    logic [1:0]                 opc_q, opc_d;

    // Requests larger than the supported term count are clamped to max_terms.
    function automatic logic [CNT_W-1:0] sat_count(input logic [CNT_W-1:0] n);
        if (n > CNT_W'(max_terms))
            return CNT_W'(max_terms);
        return n;
    endfunction

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            rem_q        <= '0;
            neg_q        <= 1'b0;
            first_wait_q <= 1'b0;
            fma_a_q      <= '0;
            fma_b_q      <= '0;
            fma_c_q      <= '0;
            opc_q        <= OPC_POS_A_POS_C;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            rem_q        <= rem_d;
            neg_q        <= neg_d;
            first_wait_q <= first_wait_d;
            fma_a_q      <= fma_a_d;
            fma_b_q      <= fma_b_d;
            fma_c_q      <= fma_c_d;
            opc_q        <= opc_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        rem_d        = rem_q;
        neg_d        = neg_q;
        first_wait_d = first_wait_q;
        fma_a_d      = fma_a_q;
        fma_b_d      = fma_b_q;
        fma_c_d      = fma_c_q;
        opc_d        = opc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    acc_d   = bias;
                    rem_d   = sat_count(term_count);
                    neg_d   = negate_products;
                    state_d = (sat_count(term_count) == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (term_valid) begin
                    fma_a_d = term_a;
                    fma_b_d = term_b;
                    fma_c_d = acc_q;
                    opc_d   = neg_q ? OPC_NEG_A_POS_C : OPC_POS_A_POS_C;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fma_input_ready) begin
                    first_wait_d = 1'b1;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                // The FMA's output flag can still be high from the previous
                // operation during the first cycle after acceptance, so it
                // is only trusted from the second WAIT cycle onward.
                first_wait_d = 1'b0;
                if (!first_wait_q && fma_output_valid) begin
                    acc_d   = fma_r;
                    rem_d   = rem_q - 1'b1;
                    state_d = (rem_q == CNT_W'(1)) ? S_DONE : S_FETCH;
                end
            end
            S_DONE: begin
                if (result_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign term_ready      = (state_q == S_FETCH);
    assign fma_input_valid = (state_q == S_ISSUE);
    assign busy            = (state_q != S_IDLE);
    assign result_valid    = (state_q == S_DONE);
    assign result          = acc_q;
    assign fma_a           = fma_a_q;
    assign fma_b           = fma_b_q;
    assign fma_c           = fma_c_q;
    assign fma_opcode      = opc_q;

endmodule

// File: tb/tb_fma_dot_product_sequencer.sv
// Scoreboard bench for fma_dot_product_sequencer. The bench uses Q16.16 values
// and a behavioural slow FMA with 3-cycle latency. The FMA's output flag stays
// high until one cycle after the next request is accepted.
module tb_fma_dot_product_sequencer;

    localparam int DW  = 32;
    localparam int CW  = 4;
    localparam int LAT = 3;
    localparam logic [1:0] POS = 2'd0;
    localparam logic [1:0] NEG = 2'd1;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 start;
    logic [CW-1:0]        term_count;
    logic signed [DW-1:0] bias;
    logic                 negate_products;
    logic                 term_valid;
    logic                 term_ready;
    logic signed [DW-1:0] term_a, term_b;
    logic                 fma_input_valid;
    logic                 fma_input_ready;
    logic signed [DW-1:0] fma_a, fma_b, fma_c;
    logic [1:0]           fma_opcode;
    logic                 fma_output_valid;
    logic signed [DW-1:0] fma_r;
    logic                 busy;
    logic                 result_valid;
    logic                 result_ready;
    logic signed [DW-1:0] result;

    always #5 clock = ~clock;

    fma_dot_product_sequencer #(.max_terms(8), .DATA_W(DW)) dut (
        .clock(clock), .reset(reset), .start(start), .term_count(term_count),
        .bias(bias), .negate_products(negate_products),
        .term_valid(term_valid), .term_ready(term_ready),
        .term_a(term_a), .term_b(term_b),
        .fma_input_valid(fma_input_valid), .fma_input_ready(fma_input_ready),
        .fma_a(fma_a), .fma_b(fma_b), .fma_c(fma_c), .fma_opcode(fma_opcode),
        .fma_output_valid(fma_output_valid), .fma_r(fma_r),
        .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
        .result(result)
    );

    int errors = 0;
    int checks = 0;
    int issues = 0;
    int results = 0;
    logic [1:0] exp_opc = POS;
    logic signed [DW-1:0] sb[$];

    function automatic logic signed [DW-1:0] fx(input real x);
        return DW'($rtoi(x * 65536.0));
    endfunction

    // ---------------- behavioural slow FMA ----------------
    logic                 stall = 1'b0;
    logic                 fma_busy, fma_clr;
    int                   fma_cnt;
    logic signed [DW-1:0] ma, mb, mc;
    logic [1:0]           mop;

    function automatic logic signed [DW-1:0] fma_calc(input logic signed [DW-1:0] a,
            input logic signed [DW-1:0] b, input logic signed [DW-1:0] c,
            input logic [1:0] op);
        logic signed [63:0] a64, b64, p;
        a64 = a;
        b64 = b;
        p = (a64 * b64) >>> 16;
        return (op == NEG) ? c - p[DW-1:0] : c + p[DW-1:0];
    endfunction

    assign fma_input_ready = !fma_busy && !stall;

    always @(posedge clock) begin
        if (reset) begin
            fma_busy <= 1'b0; fma_clr <= 1'b0; fma_cnt <= 0;
            fma_output_valid <= 1'b0; fma_r <= '0;
        end else begin
            if (fma_clr) begin
                fma_output_valid <= 1'b0;
                fma_clr <= 1'b0;
            end
            if (fma_input_valid && fma_input_ready) begin
                ma <= fma_a; mb <= fma_b; mc <= fma_c; mop <= fma_opcode;
                fma_busy <= 1'b1; fma_cnt <= LAT - 1; fma_clr <= 1'b1;
            end else if (fma_busy) begin
                if (fma_cnt == 0) begin
                    fma_busy <= 1'b0;
                    fma_output_valid <= 1'b1;
                    fma_r <= fma_calc(ma, mb, mc, mop);
                end else begin
                    fma_cnt <= fma_cnt - 1;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clock) begin
        if (!reset && fma_input_valid && fma_input_ready) begin
            issues++;
            checks++;
            if (fma_opcode !== exp_opc) begin
                errors++;
                $display("FAIL issue_opcode: got %0d expected %0d", fma_opcode, exp_opc);
            end
        end
        if (!reset && result_valid && result_ready) begin
            results++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %0d expected no result", result);
            end else begin
                logic signed [DW-1:0] e;
                e = sb.pop_front();
                if (result !== e) begin
                    errors++;
                    $display("FAIL result: got %0d expected %0d", result, e);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_op(input int tc, input real b, input logic neg);
        term_count = CW'(tc);
        bias = fx(b);
        negate_products = neg;
        exp_opc = neg ? NEG : POS;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_term(input real a, input real b);
        bit done;
        done = 1'b0;
        term_a = fx(a);
        term_b = fx(b);
        term_valid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            if (term_ready) done = 1'b1;
            tick();
        end
        term_valid = 1'b0;
        if (!done) chk("term_accept_timeout", 0, 1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        if (sb.size() != 0) begin
            chk("result_timeout", sb.size(), 0);
            sb.delete();
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_term_ready"}, term_ready, 0);
        chk({tag, "_fma_input_valid"}, fma_input_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_result_valid"}, result_valid, 0);
        chk({tag, "_result"}, result, 0);
        chk({tag, "_fma_a"}, fma_a, 0);
        chk({tag, "_fma_c"}, fma_c, 0);
        chk({tag, "_fma_opcode"}, fma_opcode, POS);
    endtask

    initial begin
        int base_i, base_r, n;
        reset = 1'b1; start = 1'b0; term_count = '0; bias = '0;
        negate_products = 1'b0; term_valid = 1'b0; term_a = '0; term_b = '0;
        result_ready = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        check_reset_outputs("reset");

        // Test 1: 0.5 + 1*2 + 0.5*4 - 1.5*2 = 1.5
        base_i = issues; base_r = results;
        sb.push_back(fx(1.5));
        start_op(3, 0.5, 1'b0);
        chk("t1_busy", busy, 1);
        send_term(1.0, 2.0);
        send_term(0.5, 4.0);
        send_term(-1.5, 2.0);
        wait_done();
        repeat (3) tick();
        chk("t1_issues", issues - base_i, 3);
        chk("t1_result_count", results - base_r, 1);
        chk("t1_idle", busy, 0);

        // Test 2: 10 - 2*3 - 1*1 = 3.0 with NEG_A_POS_C
        base_i = issues;
        sb.push_back(fx(3.0));
        start_op(2, 10.0, 1'b1);
        send_term(2.0, 3.0);
        send_term(1.0, 1.0);
        wait_done();
        chk("t2_issues", issues - base_i, 2);

        // Test 3: zero terms returns bias one cycle after start
        base_i = issues;
        sb.push_back(fx(-7.25));
        start_op(0, -7.25, 1'b0);
        chk("t3_valid_next_cycle", result_valid, 1);
        chk("t3_result", result, fx(-7.25));
        wait_done();
        repeat (2) tick();
        chk("t3_no_issue", issues - base_i, 0);

        // Test 4: gapped terms, held result, start ignored while busy
        result_ready = 1'b0;
        sb.push_back(fx(-3.0));
        start_op(2, 1.0, 1'b0);
        send_term(2.0, 0.25);
        term_count = '0; bias = fx(99.0);
        start = 1'b1; tick(); start = 1'b0;
        repeat (2) tick();
        send_term(-3.0, 1.5);
        n = 0;
        while (!result_valid && n < 100) begin tick(); n++; end
        for (int i = 0; i < 5; i++) begin
            chk("t4_hold_result", result, fx(-3.0));
            chk("t4_hold_valid", result_valid, 1);
            chk("t4_hold_busy", busy, 1);
            start = (i == 2);
            tick();
            start = 1'b0;
        end
        result_ready = 1'b1;
        tick();
        chk("t4_valid_dropped", result_valid, 0);
        chk("t4_busy_dropped", busy, 0);
        wait_done();

        // Test 5: FMA back-pressure, operands held stable
        base_i = issues;
        stall = 1'b1;
        sb.push_back(fx(-1.0));
        start_op(1, 2.0, 1'b0);
        send_term(1.5, -2.0);
        for (int i = 0; i < 4; i++) begin
            chk("t5_valid", fma_input_valid, 1);
            chk("t5_fma_a", fma_a, fx(1.5));
            chk("t5_fma_b", fma_b, fx(-2.0));
            chk("t5_fma_c", fma_c, fx(2.0));
            chk("t5_opcode", fma_opcode, POS);
            tick();
        end
        stall = 1'b0;
        wait_done();
        chk("t5_single_issue", issues - base_i, 1);

        // Test 6: reset during WAIT of term 2, then a fresh operation
        base_i = issues;
        start_op(3, 0.0, 1'b0);
        send_term(1.0, 1.0);
        send_term(2.0, 2.0);
        n = 0;
        while (issues < base_i + 2 && n < 100) begin tick(); n++; end
        chk("t6_reached_wait", issues - base_i, 2);
        tick();
        reset = 1'b1;
        tick();
        check_reset_outputs("t6");
        reset = 1'b0;
        tick();
        sb.push_back(fx(7.0));
        start_op(1, 1.0, 1'b0);
        send_term(3.0, 2.0);
        wait_done();

        // Test 7: term_count above max_terms saturates to 8 terms
        base_i = issues;
        sb.push_back(fx(8.0));
        start_op(15, 0.0, 1'b0);
        for (int i = 0; i < 8; i++) send_term(1.0, 1.0);
        wait_done();
        tick();
        chk("t7_issues", issues - base_i, 8);
        chk("t7_no_more_terms", term_ready, 0);

        repeat (5) tick();
        chk("final_scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
